// File: rtl/pipe_share_arb_if.sv
// ---------------------------------------------------------------------------
// pipe_share_arb_if
// Bundles every signal of the shared-pipeline arbiter except clock and reset.
//   requester side : req_i, a0_i/b0_i, a1_i/b1_i in; gnt_o out
//   pipeline side  : pipe_valid_o, pipe_a_o, pipe_b_o out;
//                    pipe_valid_i, pipe_y_i in
//   response side  : rsp_valid_o, rsp0_y_o, rsp1_y_o out; rsp_ready_i in
//   status         : busy_o, err_o out
// The slave modport is the arbiter's view; master is everything around it.
// ---------------------------------------------------------------------------
interface pipe_share_arb_if #(
  parameter int DW = 8
);
  logic [1:0]    req_i;
  logic [DW-1:0] a0_i;
  logic [DW-1:0] b0_i;
  logic [DW-1:0] a1_i;
  logic [DW-1:0] b1_i;
  logic [1:0]    gnt_o;
  logic          pipe_valid_o;
  logic [DW-1:0] pipe_a_o;
  logic [DW-1:0] pipe_b_o;
  logic          pipe_valid_i;
  logic [DW-1:0] pipe_y_i;
  logic [1:0]    rsp_valid_o;
  logic [1:0]    rsp_ready_i;
  logic [DW-1:0] rsp0_y_o;
  logic [DW-1:0] rsp1_y_o;
  logic          busy_o;
  logic          err_o;

  modport slave (
    input  req_i, a0_i, b0_i, a1_i, b1_i,
    output gnt_o,
    output pipe_valid_o, pipe_a_o, pipe_b_o,
    input  pipe_valid_i, pipe_y_i,
    output rsp_valid_o, rsp0_y_o, rsp1_y_o,
    input  rsp_ready_i,
    output busy_o, err_o
  );

  modport master (
    output req_i, a0_i, b0_i, a1_i, b1_i,
    input  gnt_o,
    input  pipe_valid_o, pipe_a_o, pipe_b_o,
    output pipe_valid_i, pipe_y_i,
    input  rsp_valid_o, rsp0_y_o, rsp1_y_o,
    output rsp_ready_i,
    input  busy_o, err_o
  );
endinterface

// File: rtl/pipe_share_arb.sv
// ---------------------------------------------------------------------------
// pipe_share_arb
// Two-channel round-robin front end for a fixed-latency, non-stalling
// arithmetic pipeline. Grants at most one request per cycle, issues it on
// registered pipe_* outputs, tracks the owning channel alongside the
// pipeline, and steers each result into a per-channel fall-through FIFO.
// Per-channel credits (in flight + queued) never exceed DEPTH, so a result
// always finds room in its FIFO.
// Ports:
//   CLK  - rising-edge clock
//   RST  - asynchronous active-low reset
//   bus  - pipe_share_arb_if.slave (requests, pipeline, responses, status)
// ---------------------------------------------------------------------------
module pipe_share_arb #(
  parameter int DW    = 8,
  parameter int LAT   = 3,
  parameter int DEPTH = 2
) (
  input logic             CLK,
  input logic             RST,
  pipe_share_arb_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [CW-1:0] cnt    [2];
  logic [CW-1:0] occ    [2];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic [DW-1:0] mem    [2][DEPTH];

  // Tag pipe: index 0 is the op issued this cycle, index LAT lines up with
  // the pipeline's own valid_o.
  logic [LAT:0]  tag_v;
  logic [LAT:0]  tag_ch;

  logic          last_ch;
  logic          err_q;
  logic          issue_v;
  logic [DW-1:0] issue_a;
  logic [DW-1:0] issue_b;

  logic [1:0]    elig;
  logic [1:0]    gnt;
  logic [1:0]    nonempty;
  logic [1:0]    pop;
  logic [1:0]    push;
  logic [1:0]    lost;
  logic [1:0]    drop_full;
  logic [1:0]    head_sel;
  logic          head_v;
  logic          bad_valid;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Eligibility looks only at the registered credit count, so a pop in the
  // same cycle cannot open a slot until the next one. On a tie the channel
  // that did not win last time goes first.
  always_comb begin
    elig[0] = bus.req_i[0] && (cnt[0] < DEPTH_C);
    elig[1] = bus.req_i[1] && (cnt[1] < DEPTH_C);
    gnt     = elig;
    if (elig == 2'b11) begin
      gnt = last_ch ? 2'b01 : 2'b10;
    end
  end

  // Result steering. A pipeline valid with no matching tag is a protocol
  // error; a tag with no pipeline valid means the op vanished and its credit
  // must be returned.
  always_comb begin
    head_v    = tag_v[LAT];
    head_sel  = {tag_ch[LAT], ~tag_ch[LAT]};
    bad_valid = bus.pipe_valid_i && !head_v;
    nonempty  = '0;
    pop       = '0;
    push      = '0;
    lost      = '0;
    drop_full = '0;
    for (int ch = 0; ch < 2; ch++) begin
      nonempty[ch] = (occ[ch] != '0);
      pop[ch]      = nonempty[ch] && bus.rsp_ready_i[ch];
      lost[ch]     = head_v && head_sel[ch] && !bus.pipe_valid_i;
      if (bus.pipe_valid_i && head_v && head_sel[ch]) begin
        if ((occ[ch] != DEPTH_C) || pop[ch]) begin
          push[ch] = 1'b1;
        end else begin
          drop_full[ch] = 1'b1;
        end
      end
    end
  end

  // Issue register; operands hold when nothing is granted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      issue_v <= 1'b0;
      issue_a <= '0;
      issue_b <= '0;
      last_ch <= 1'b1;
    end else begin
      issue_v <= |gnt;
      if (gnt[0]) begin
        issue_a <= bus.a0_i;
        issue_b <= bus.b0_i;
      end else if (gnt[1]) begin
        issue_a <= bus.a1_i;
        issue_b <= bus.b1_i;
      end
      if (|gnt) begin
        last_ch <= gnt[1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tag_v  <= '0;
      tag_ch <= '0;
    end else begin
      tag_v  <= {tag_v[LAT-1:0], |gnt};
      tag_ch <= {tag_ch[LAT-1:0], gnt[1]};
    end
  end

  // Credits and FIFOs. An op dropped on a full FIFO is gone as well, so it
  // gives its credit back like a lost op.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int ch = 0; ch < 2; ch++) begin
        cnt[ch]    <= '0;
        occ[ch]    <= '0;
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem[ch][i] <= '0;
        end
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        cnt[ch] <= cnt[ch] + CW'(gnt[ch]) - CW'(pop[ch])
                   - CW'(lost[ch]) - CW'(drop_full[ch]);
        occ[ch] <= occ[ch] + CW'(push[ch]) - CW'(pop[ch]);
        if (push[ch]) begin
          mem[ch][wr_ptr[ch]] <= bus.pipe_y_i;
          wr_ptr[ch]          <= ptr_next(wr_ptr[ch]);
        end
        if (pop[ch]) begin
          rd_ptr[ch] <= ptr_next(rd_ptr[ch]);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | bad_valid | (|lost) | (|drop_full);
    end
  end

  assign bus.gnt_o        = gnt;
  assign bus.pipe_valid_o = issue_v;
  assign bus.pipe_a_o     = issue_a;
  assign bus.pipe_b_o     = issue_b;
  assign bus.rsp_valid_o  = nonempty;
  assign bus.rsp0_y_o     = mem[0][rd_ptr[0]];
  assign bus.rsp1_y_o     = mem[1][rd_ptr[1]];
  assign bus.busy_o       = (|tag_v) || (|nonempty);
  assign bus.err_o        = err_q;

endmodule

// File: doc/pipe_share_arb.md
Name: pipe_share_arb

Overview:
- Two-requester round-robin arbiter/scheduler for the shared 3-stage arithmetic pipeline, which computes y = ((a+b)*b + a)*b and has fixed latency and a valid bit per stage.
- Accepts operand requests, issues at most one operation per cycle into the pipeline, and tags each operation with its channel.
- Steers each pipeline result into a per-channel response FIFO with ready/valid backpressure.
- Credit accounting guarantees a result never arrives to a full FIFO; the pipeline itself has no stall.

Parameters:
- DW, 8, operand/result width (matches pipeline a_i/b_i/y_o).
- LAT, 3, pipeline latency: pipe_valid_o cycle to pipe_valid_i cycle.
- DEPTH, 2, entries per response FIFO; also per-channel credit limit.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- req_i  in  2  request per channel; held with operands until granted.
- a0_i, b0_i  in  DW each  channel 0 operands.
- a1_i, b1_i  in  DW each  channel 1 operands.
- gnt_o  out  2  one-hot accept pulse (combinational), at most one bit set.
- pipe_valid_o  out  1  issue strobe to pipeline valid_i (registered).
- pipe_a_o, pipe_b_o  out  DW each  operands to pipeline (registered).
- pipe_valid_i  in  1  pipeline valid_o.
- pipe_y_i  in  DW  pipeline y_o.
- rsp_valid_o  out  2  per-channel FIFO non-empty.
- rsp_ready_i  in  2  per-channel consumer ready; pop on valid&&ready.
- rsp0_y_o, rsp1_y_o  out  DW each  FIFO head data.
- busy_o  out  1  any op in flight or any FIFO non-empty.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (RST low, async): pipe_valid_o=0, pipe_a_o/pipe_b_o=0, FIFOs empty, rsp_valid_o=0, rsp data=0, credit counters=0, tag pipe cleared, RR pointer selects ch0 first, err_o=0, busy_o=0.
- The pipeline shares RST, so in-flight ops are discarded with no result. Reset mid-operation gives no response and no err_o.
- Credit: cnt[ch] = in-flight ops + FIFO occupancy, range 0..DEPTH.
  - +1 on grant; -1 on pop; both in the same cycle leaves it unchanged.
  - Channel is eligible iff req_i[ch] && cnt[ch] < DEPTH, using the registered cnt only. A pop does not free a slot in the same cycle.
- Arbitration:
  - One eligible channel: it is granted.
  - Both eligible: grant the channel not granted last. The pointer updates only on a grant.
  - Neither eligible: gnt_o=0 and no issue.
- Issue: grant in cycle t gives pipe_valid_o=1 in t+1 with the granted channel's operands. Otherwise pipe_valid_o=0 and the operand outputs hold.
- Tag pipe: LAT+1 entries of {valid, ch}, loaded at the grant edge and shifted every cycle. The head entry is aligned with pipe_valid_i, i.e. cycle t+1+LAT.
- Result steering:
  - pipe_valid_i with a valid head tag: push pipe_y_i into FIFO[head.ch].
  - pipe_valid_i with an invalid head tag: set err_o and drop the data.
  - Valid head tag without pipe_valid_i: set err_o and decrement cnt[head.ch] (op lost).
- Total latency: gnt_o in cycle t gives rsp_valid_o in cycle t+2+LAT (t+5 at the defaults).
- FIFO:
  - Circular, DEPTH entries, wrap-around pointers, first-word fall-through.
  - Push and pop in the same cycle are legal at any occupancy, including full (the credit guarantees no overflow).
  - Push to a full FIFO is impossible by construction; if it occurs, set err_o and drop.
- Requests are not queued inside the block. Dropping req_i before grant is legal and causes no side effects.
- Arithmetic belongs to the pipeline; this block passes DW-bit data unchanged.

Test Plan:
- Single op: req_i=01, a0=2, b0=3 at t0 -> gnt_o=01 in t0; pipe_valid_o in t1; rsp_valid_o[0]=1 with rsp0_y_o=51 at t5; pop clears it and busy_o returns to 0.
- Contention: req_i=11 held, both channels ready=1, a0=1,b0=1 and a1=2,b1=3 -> grants alternate 01,10,01,...; ch0 responses=3, ch1 responses=51, each in issue order.
- Backpressure: ch0 requests continuously, rsp_ready_i[0]=0 -> exactly DEPTH=2 grants, then gnt_o[0]=0. Raise ready for one cycle -> one pop, then one new grant on the following cycle.
- Credit starvation fairness: ch0 credit-blocked, ch1 requesting -> ch1 granted every cycle, pointer lands on ch1. Unblock ch0 -> ch0 wins the next tie.
- Reset mid-flight: assert RST with 2 ops in flight and 1 FIFO entry -> all outputs at reset values immediately; after release no rsp_valid_o and err_o=0.
- Error injection: force pipe_valid_i=1 with no issue -> err_o=1 and stays set until RST; FIFOs unchanged.
